uart_tx_engine: RTL

//  Parametrised UART transmit engine: buffers words in a FIFO and serialises them as start/data/[parity]/stop frames on UART_SOUT.

---
 rtl/uart_tx_engine.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-buffered UART transmitter, start/data/[parity]/stop framing.
// Define UART_TX_PARITY_EN to build the optional parity bit stage.
module uart_tx_engine #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int TX_THRESH  = 8
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [DIV_W-1:0]              divisor,
  input  logic                          stop2,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  output logic                          UART_SOUT,
  output logic                          TXDRDYn,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_W);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [LW-1:0]     r_level;
  state_t            r_state;
  logic [DIV_W-1:0]  r_div_m1, r_cnt;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_stop2, r_sout, r_rdyn, r_ovf;
  logic              w_full, w_push, w_pop, w_tick, w_stop_end, w_par_bit, w_sout_nx;
  logic [LW-1:0]     w_level_nx;
  logic [DIV_W-1:0]  w_div_m1;
  assign w_full     = r_level == LW'(FIFO_DEPTH);
  assign w_push     = wr_en && !w_full;
  assign w_tick     = r_cnt == '0;
  assign w_stop_end = r_state == STOP && w_tick && r_bit == '0;
  assign w_pop      = r_level != '0 && (r_state == IDLE || w_stop_end);
  assign w_level_nx = r_level + LW'(w_push) - LW'(w_pop);
  assign w_div_m1   = divisor == '0 ? '0 : divisor - 1'b1;
`ifdef UART_TX_PARITY_EN
  logic r_par_en, r_par;
  assign w_par_bit = r_state == PARITY ? r_par : 1'b1;
`else
  logic w_unused_par;
  assign w_unused_par = parity_en ^ parity_odd;
  assign w_par_bit = 1'b1;
`endif
  // Line is registered from the pre-edge state, so it trails the FSM by one cycle.
  assign w_sout_nx = r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : w_par_bit;
  always_ff @(posedge PCLK)
    if (w_push) r_mem[r_wp] <= wr_data;
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_rdyn  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_level <= w_level_nx;
      r_ovf   <= wr_en && w_full;
      r_rdyn  <= !(w_level_nx <= LW'(TX_THRESH));
    end
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_div_m1 <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_stop2  <= 1'b0;
      r_sout   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
`endif
    end else begin
      r_sout <= w_sout_nx;
      if (w_pop) begin
        r_state  <= START;
        r_shift  <= r_mem[r_rp];
        r_div_m1 <= w_div_m1;
        r_cnt    <= w_div_m1;
        r_stop2  <= stop2;
`ifdef UART_TX_PARITY_EN
        r_par_en <= parity_en;
        r_par    <= ^r_mem[r_rp] ^ parity_odd;
`endif
      end else if (r_state != IDLE) begin
        if (!w_tick) r_cnt <= r_cnt - 1'b1;
        else begin
          r_cnt <= r_div_m1;
          case (r_state)
            START: begin
              r_state <= DATA;
              r_bit   <= BW'(DATA_W - 1);
            end
            DATA: begin
              r_shift <= r_shift >> 1;
              if (r_bit == '0) begin
`ifdef UART_TX_PARITY_EN
                r_state <= r_par_en ? PARITY : STOP;
`else
                r_state <= STOP;
`endif
                r_bit <= BW'(r_stop2);
              end else r_bit <= r_bit - 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              r_state <= STOP;
              r_bit   <= BW'(r_stop2);
            end
`endif
            STOP: begin
              if (r_bit == '0) r_state <= IDLE;
              else r_bit <= r_bit - 1'b1;
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end
  assign UART_SOUT = r_sout;
  assign TXDRDYn   = r_rdyn;
  assign full      = w_full;
  assign level     = r_level;
  assign busy      = r_state != IDLE;
  assign overflow  = r_ovf;
endmodule
